// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: bus-timing engine for the HD44780-style character LCD.
// Accepts one instruction/data byte per valid/ready handshake, drives DB/RS,
// produces the ENABLE strobe with setup/pulse/hold timing, then waits out the
// controller execution time (long wait for clear/home, short otherwise).
module lcd_byte_writer #(
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned PULSE_CYCLES      = 12,
    parameter int unsigned HOLD_CYCLES       = 1,
    parameter int unsigned SHORT_EXEC_CYCLES = 2000,
    parameter int unsigned LONG_EXEC_CYCLES  = 82000
) (
    input  logic       CLOCK_50MHZ,
    input  logic       RESET_N,
    input  logic       CMD_VALID,
    input  logic       CMD_RS,
    input  logic [7:0] CMD_DATA,
    output logic       CMD_READY,
    output logic       CMD_DONE,
    output logic [7:0] LCD_DATA_BIT,
    output logic       LCD_ENABLE,
    output logic       LCD_REGISTER_SELECT,
    output logic       LCD_READ_WRITE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4
    } state_t;

    // Terminal count for each phase; a phase of N cycles ends at count N-1.
    localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYCLES) - 32'd1;
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES) - 32'd1;
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES) - 32'd1;
    localparam logic [31:0] SHORT_LAST = 32'(SHORT_EXEC_CYCLES) - 32'd1;
    localparam logic [31:0] LONG_LAST  = 32'(LONG_EXEC_CYCLES) - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        long_q, long_d;
    logic        enable_q, enable_d;
    logic        done_q, done_d;

    logic        accept;
    logic        is_long_cmd;
    logic [31:0] exec_last;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign is_long_cmd = !CMD_RS &&
                         ((CMD_DATA == 8'h01) || (CMD_DATA == 8'h02) || (CMD_DATA == 8'h03));
    assign accept      = CMD_VALID && (state_q == IDLE);
    assign exec_last   = long_q ? LONG_LAST : SHORT_LAST;

    // Next-state, counter, capture and strobe decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q + 32'd1;
        data_d   = data_q;
        rs_d     = rs_q;
        long_d   = long_q;
        done_d   = 1'b0;
        enable_d = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (accept) begin
                    state_d = SETUP;
                    data_d  = CMD_DATA;
                    rs_d    = CMD_RS;
                    long_d  = is_long_cmd;
                end
            end
            SETUP: begin
                if (count_q == SETUP_LAST) begin
                    state_d = PULSE;
                    count_d = '0;
                end
            end
            PULSE: begin
                if (count_q == PULSE_LAST) begin
                    state_d = HOLD;
                    count_d = '0;
                end
            end
            HOLD: begin
                if (count_q == HOLD_LAST) begin
                    state_d = EXEC;
                    count_d = '0;
                end
            end
            EXEC: begin
                if (count_q == exec_last) begin
                    state_d = IDLE;
                    count_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        // ENABLE is a flop decoded from the next state so it never glitches.
        enable_d = (state_d == PULSE);
    end

    // State, counter and registered outputs; async reset drops any byte in flight.
    always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            count_q  <= '0;
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            long_q   <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            long_q   <= long_d;
            enable_q <= enable_d;
            done_q   <= done_d;
        end
    end

    assign CMD_READY           = (state_q == IDLE);
    assign CMD_DONE            = done_q;
    assign LCD_DATA_BIT        = data_q;
    assign LCD_ENABLE          = enable_q;
    assign LCD_REGISTER_SELECT = rs_q;
    assign LCD_READ_WRITE      = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer: table-driven and random scoreboard bench for lcd_byte_writer.
// Instance 0 uses default timing, instance 1 short execution waits for stream and
// reset tests, instance 2 all parameters at 1 for a random handshake stream.
`timescale 1ns/1ps
module tb_lcd_byte_writer;

    localparam int NI = 3;
    localparam int NV = 12;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [NI];
    logic       cmd_valid [NI];
    logic       cmd_rs    [NI];
    logic [7:0] cmd_data  [NI];
    logic       ready     [NI];
    logic       done      [NI];
    logic [7:0] lcd_db    [NI];
    logic       lcd_en    [NI];
    logic       lcd_rs    [NI];
    logic       lcd_rw    [NI];

    lcd_byte_writer u_def (
        .CLOCK_50MHZ(clk), .RESET_N(rst_n[0]), .CMD_VALID(cmd_valid[0]), .CMD_RS(cmd_rs[0]),
        .CMD_DATA(cmd_data[0]), .CMD_READY(ready[0]), .CMD_DONE(done[0]), .LCD_DATA_BIT(lcd_db[0]),
        .LCD_ENABLE(lcd_en[0]), .LCD_REGISTER_SELECT(lcd_rs[0]), .LCD_READ_WRITE(lcd_rw[0])
    );

    lcd_byte_writer #(
        .SETUP_CYCLES(2), .PULSE_CYCLES(12), .HOLD_CYCLES(1),
        .SHORT_EXEC_CYCLES(40), .LONG_EXEC_CYCLES(90)
    ) u_mid (
        .CLOCK_50MHZ(clk), .RESET_N(rst_n[1]), .CMD_VALID(cmd_valid[1]), .CMD_RS(cmd_rs[1]),
        .CMD_DATA(cmd_data[1]), .CMD_READY(ready[1]), .CMD_DONE(done[1]), .LCD_DATA_BIT(lcd_db[1]),
        .LCD_ENABLE(lcd_en[1]), .LCD_REGISTER_SELECT(lcd_rs[1]), .LCD_READ_WRITE(lcd_rw[1])
    );

    lcd_byte_writer #(
        .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1),
        .SHORT_EXEC_CYCLES(1), .LONG_EXEC_CYCLES(1)
    ) u_min (
        .CLOCK_50MHZ(clk), .RESET_N(rst_n[2]), .CMD_VALID(cmd_valid[2]), .CMD_RS(cmd_rs[2]),
        .CMD_DATA(cmd_data[2]), .CMD_READY(ready[2]), .CMD_DONE(done[2]), .LCD_DATA_BIT(lcd_db[2]),
        .LCD_ENABLE(lcd_en[2]), .LCD_REGISTER_SELECT(lcd_rs[2]), .LCD_READ_WRITE(lcd_rw[2])
    );

    // Timing of each instance as configured above.
    function automatic longint p_setup(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic longint p_pulse(input int i);
        return (i == 2) ? 1 : 12;
    endfunction
    function automatic longint p_hold(input int i);
        return 1;
    endfunction
    function automatic longint p_exec(input int i, input logic lg);
        if (i == 0) return lg ? 82000 : 2000;
        if (i == 1) return lg ? 90 : 40;
        return 1;
    endfunction
    function automatic longint p_total(input int i, input logic lg);
        return p_setup(i) + p_pulse(i) + p_hold(i) + p_exec(i, lg);
    endfunction
    function automatic logic is_long(input logic r, input logic [7:0] d);
        return !r && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       lg;
        longint     t;
    } exp_t;

    typedef struct {
        int         inst;
        logic       rs;
        logic [7:0] data;
        logic       lg;
        logic       drop;
    } vec_t;

    exp_t   sb_q [NI][$];
    vec_t   vecs [NV];

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;

    logic       en_prev    [NI];
    longint     rise_cyc   [NI];
    int         pulses_cur [NI];
    int         pulses_tot [NI];
    int         dones_tot  [NI];
    int         accepts    [NI];
    int         ready_err  [NI];
    int         db_err     [NI];
    int         rw_high    [NI];
    logic [7:0] last_db    [NI];
    logic       last_rs    [NI];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name, input int i);
        n_vec++;
        n_err++;
        $display("FAIL %s inst %0d: wait bound expired (cycle %0d)", name, i, cyc);
    endtask

    task automatic push(input int i, input logic r, input logic [7:0] d, input logic lg);
        exp_t e;
        e.rs   = r;
        e.data = d;
        e.lg   = lg;
        e.t    = cyc + 1;
        sb_q[i].push_back(e);
        last_db[i] = d;
        last_rs[i] = r;
        accepts[i]++;
    endtask

    // Per-cycle observation of one instance, run on the falling edge.
    task automatic mon_step(input int i);
        longint t_done;
        logic   exp_rdy;
        exp_t   h;
        if (rst_n[i] !== 1'b1) begin
            en_prev[i] = 1'b0;
            return;
        end
        if (lcd_rw[i] !== 1'b0) rw_high[i]++;
        if (lcd_db[i] !== last_db[i] || lcd_rs[i] !== last_rs[i]) db_err[i]++;
        t_done  = -1;
        if (sb_q[i].size() > 0) begin
            h      = sb_q[i][0];
            t_done = h.t + p_total(i, h.lg);
        end
        exp_rdy = (sb_q[i].size() == 0) || (cyc == t_done);
        if (ready[i] !== exp_rdy) ready_err[i]++;
        if (lcd_en[i] === 1'b1 && !en_prev[i]) begin
            if (sb_q[i].size() == 0) begin
                check($sformatf("pulse_without_byte inst%0d", i), sb_q[i].size(), 1);
            end else begin
                check($sformatf("enable_rise_cycle inst%0d", i), cyc, h.t + p_setup(i));
                check($sformatf("db_during_pulse inst%0d", i), lcd_db[i], h.data);
                check($sformatf("rs_during_pulse inst%0d", i), lcd_rs[i], h.rs);
            end
            rise_cyc[i] = cyc;
            pulses_cur[i]++;
            pulses_tot[i]++;
        end
        if (lcd_en[i] !== 1'b1 && en_prev[i]) begin
            check($sformatf("enable_width inst%0d", i), cyc - rise_cyc[i], p_pulse(i));
        end
        en_prev[i] = (lcd_en[i] === 1'b1);
        if (done[i] === 1'b1) begin
            if (sb_q[i].size() == 0) begin
                check($sformatf("done_without_byte inst%0d", i), sb_q[i].size(), 1);
            end else begin
                check($sformatf("done_cycle inst%0d", i), cyc, t_done);
                check($sformatf("pulses_per_byte inst%0d", i), pulses_cur[i], 1);
                $display("inst %0d: rs=%0d data=0x%02h accepted edge %0d done cycle %0d",
                         i, h.rs, h.data, h.t, cyc);
                void'(sb_q[i].pop_front());
                pulses_cur[i] = 0;
                dones_tot[i]++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) mon_step(i);
    end

    // Offer one byte, junk on DB/RS lines while the writer is busy; t = transfer edge.
    task automatic send(input int i, input logic r, input logic [7:0] d, input logic lg,
                        input logic drop, output longint t);
        int waited;
        waited = 0;
        t = -1;
        @(negedge clk); #1;
        while (ready[i] !== 1'b1) begin
            if (waited >= 200000) begin
                timeout_fail("ready_timeout", i);
                return;
            end
            cmd_data[i] = 8'($urandom);
            cmd_rs[i]   = 1'($urandom);
            @(negedge clk); #1;
            waited++;
        end
        cmd_valid[i] = 1'b1;
        cmd_rs[i]    = r;
        cmd_data[i]  = d;
        push(i, r, d, lg);
        t = cyc + 1;
        @(negedge clk); #1;
        if (drop) cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int w;
        w = 0;
        while (sb_q[i].size() != 0) begin
            @(negedge clk); #1;
            w++;
            if (w > 100000) begin
                timeout_fail("done_timeout", i);
                sb_q[i].delete();
                return;
            end
        end
    endtask

    task automatic run_table(input int i);
        longint t, prev_t;
        logic   prev_stream, prev_lg;
        prev_stream = 1'b0;
        prev_lg     = 1'b0;
        prev_t      = 0;
        for (int k = 0; k < NV; k++) begin
            if (vecs[k].inst == i) begin
                send(i, vecs[k].rs, vecs[k].data, vecs[k].lg, vecs[k].drop, t);
                if (prev_stream)
                    check($sformatf("transfer_spacing inst%0d byte%0d", i, k), t - prev_t,
                          p_total(i, prev_lg) + 1);
                prev_stream = !vecs[k].drop;
                prev_t      = t;
                prev_lg     = vecs[k].lg;
                if (vecs[k].drop) wait_idle(i);
            end
        end
    endtask

    task automatic thread_def();
        repeat (100) @(negedge clk);
        #1;
        check("idle_db", lcd_db[0], 8'h00);
        check("idle_enable", lcd_en[0], 1'b0);
        check("idle_ready", ready[0], 1'b1);
        check("idle_done_count", dones_tot[0], 0);
        run_table(0);
    endtask

    task automatic thread_mid();
        longint t;
        int     d0, w;
        run_table(1);
        // Reset while ENABLE is high: outputs clear at once, no DONE ever follows.
        d0 = dones_tot[1];
        send(1, 1'b1, 8'h5A, 1'b0, 1'b1, t);
        w = 0;
        while (lcd_en[1] !== 1'b1) begin
            @(negedge clk); #1;
            w++;
            if (w > 100) begin
                timeout_fail("enable_wait", 1);
                break;
            end
        end
        #2;
        rst_n[1] = 1'b0;
        #1;
        check("rst_mid_enable", lcd_en[1], 1'b0);
        check("rst_mid_db", lcd_db[1], 8'h00);
        check("rst_mid_rs", lcd_rs[1], 1'b0);
        check("rst_mid_rw", lcd_rw[1], 1'b0);
        check("rst_mid_ready", ready[1], 1'b1);
        check("rst_mid_done", done[1], 1'b0);
        sb_q[1].delete();
        last_db[1]    = 8'h00;
        last_rs[1]    = 1'b0;
        pulses_cur[1] = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hold_done", done[1], 1'b0);
        rst_n[1] = 1'b1;
        repeat (int'(p_total(1, 1'b1)) + 20) @(negedge clk);
        #1;
        check("rst_dropped_no_done", dones_tot[1], d0);
        send(1, 1'b0, 8'h0C, 1'b0, 1'b1, t);
        wait_idle(1);
        check("after_rst_done", dones_tot[1], d0 + 1);
    endtask

    task automatic thread_min();
        logic took;
        took = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (cmd_valid[2] !== 1'b1 || took) begin
                cmd_valid[2] = ($urandom_range(0, 3) != 0);
                cmd_rs[2]    = 1'($urandom_range(0, 1));
                cmd_data[2]  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            end
            took = 1'b0;
            if (cmd_valid[2] === 1'b1 && ready[2] === 1'b1) begin
                push(2, cmd_rs[2], cmd_data[2], is_long(cmd_rs[2], cmd_data[2]));
                took = 1'b1;
            end
        end
        @(negedge clk); #1;
        cmd_valid[2] = 1'b0;
        wait_idle(2);
        check("rand_done_vs_accepts", dones_tot[2], accepts[2]);
        check("rand_pulses_vs_accepts", pulses_tot[2], accepts[2]);
    endtask

    initial begin
        vecs[0]  = '{0, 1'b0, 8'h38, 1'b0, 1'b1};
        vecs[1]  = '{0, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[2]  = '{0, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[3]  = '{1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[4]  = '{1, 1'b1, 8'h44, 1'b0, 1'b0};
        vecs[5]  = '{1, 1'b1, 8'h4D, 1'b0, 1'b1};
        vecs[6]  = '{1, 1'b0, 8'h02, 1'b1, 1'b1};
        vecs[7]  = '{1, 1'b0, 8'h03, 1'b1, 1'b1};
        vecs[8]  = '{1, 1'b0, 8'h04, 1'b0, 1'b1};
        vecs[9]  = '{1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{1, 1'b1, 8'h02, 1'b0, 1'b1};
        vecs[11] = '{1, 1'b0, 8'hFF, 1'b0, 1'b1};
        for (int i = 0; i < NI; i++) begin
            rst_n[i]      = 1'b1;
            cmd_valid[i]  = 1'b0;
            cmd_rs[i]     = 1'b0;
            cmd_data[i]   = 8'h00;
            en_prev[i]    = 1'b0;
            rise_cyc[i]   = 0;
            pulses_cur[i] = 0;
            pulses_tot[i] = 0;
            dones_tot[i]  = 0;
            accepts[i]    = 0;
            ready_err[i]  = 0;
            db_err[i]     = 0;
            rw_high[i]    = 0;
            last_db[i]    = 8'h00;
            last_rs[i]    = 1'b0;
        end
        #1;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_ready inst%0d", i), ready[i], 1'b1);
            check($sformatf("reset_enable inst%0d", i), lcd_en[i], 1'b0);
            check($sformatf("reset_db inst%0d", i), lcd_db[i], 8'h00);
            check($sformatf("reset_rs inst%0d", i), lcd_rs[i], 1'b0);
            check($sformatf("reset_rw inst%0d", i), lcd_rw[i], 1'b0);
            check($sformatf("reset_done inst%0d", i), done[i], 1'b0);
        end
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

        fork
            thread_def();
            thread_mid();
            thread_min();
        join

        for (int i = 0; i < NI; i++) begin
            check($sformatf("ready_tracking inst%0d", i), ready_err[i], 0);
            check($sformatf("db_rs_stability inst%0d", i), db_err[i], 0);
            check($sformatf("rw_never_high inst%0d", i), rw_high[i], 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_byte_writer.md
# lcd_byte_writer

Bus-timing engine for the Spartan 3AN Starter Kit character LCD, placed directly downstream of the LCD init/message sequencer. It accepts one command or data byte per valid/ready handshake. For each byte it drives the LCD data, register-select and read/write lines and generates the ENABLE strobe with the required setup, pulse and hold timing. It then holds off the next byte for the controller execution time, choosing the long wait for clear/home commands and the short wait for everything else.

## Interface
- SETUP_CYCLES, 2: cycles DB/RS are stable with ENABLE low before ENABLE rises (≥1).
- PULSE_CYCLES, 12: cycles ENABLE is held high (≥1).
- HOLD_CYCLES, 1: cycles DB/RS are held after ENABLE falls (≥1).
- SHORT_EXEC_CYCLES, 2000: execution wait for normal commands and data, 40 µs at 50 MHz (≥1).
- LONG_EXEC_CYCLES, 82000: execution wait for clear/home commands, 1.64 ms (≥1).

Ports:
- CLOCK_50MHZ  in  1  system clock.
- RESET_N  in  1  asynchronous reset, active-low.
- CMD_VALID  in  1  upstream offers a byte.
- CMD_RS  in  1  0 = instruction, 1 = data.
- CMD_DATA  in  8  byte to write.
- CMD_READY  out  1  writer can accept a byte.
- CMD_DONE  out  1  one-cycle pulse when a byte's execution wait has elapsed.
- LCD_DATA_BIT  out  8  LCD DB[7:0].
- LCD_ENABLE  out  1  LCD E strobe.
- LCD_REGISTER_SELECT  out  1  LCD RS.
- LCD_READ_WRITE  out  1  LCD R/W, constant 0 (write only).

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
- CMD_READY is high exactly when the state is IDLE. It is decoded from the state register, so it is high during reset.
- Transfer occurs on a rising edge where CMD_VALID=1 and CMD_READY=1.
  - CMD_RS and CMD_DATA are captured into registers.
  - The state goes to SETUP and the cycle counter clears.
- CMD_VALID while not in IDLE is ignored. Upstream must hold the byte until it is accepted.
- Long-wait select is latched at transfer: RS=0 and DATA ∈ {0x01, 0x02, 0x03}. All other bytes, including RS=1 with any value, use SHORT_EXEC_CYCLES.
- One 32-bit counter is shared by all states. Each state exits when count == N−1, where N is the state's parameter; the counter resets to 0 on every state change.
- State sequence and outputs:
  - SETUP: ENABLE=0.
  - PULSE: ENABLE=1.
  - HOLD: ENABLE=0.
  - EXEC: ENABLE=0.
  - EXEC exits to IDLE and asserts CMD_DONE for exactly the first IDLE cycle.
- LCD_DATA_BIT and LCD_REGISTER_SELECT come from the capture registers. They change only at transfer and keep the last byte while IDLE.
- All outputs are registered except CMD_READY. ENABLE has no glitches.
- Reset (async, RESET_N=0), effective immediately, including mid-transaction:
  - State = IDLE and counter = 0.
  - LCD_ENABLE = 0, LCD_DATA_BIT = 0x00, LCD_REGISTER_SELECT = 0, LCD_READ_WRITE = 0.
  - CMD_DONE = 0.
  - A byte in flight is dropped and no CMD_DONE is issued for it.

## Timing
- Let T be the transfer edge.
- LCD_DATA_BIT and RS are valid from T.
- ENABLE rises at T+SETUP_CYCLES and falls at T+SETUP_CYCLES+PULSE_CYCLES.
- The state enters IDLE at T+S+P+H+E, where S, P, H and E are the SETUP, PULSE, HOLD and selected EXEC cycle counts.
  - CMD_READY=1 and CMD_DONE=1 in the cycle following that edge.
- Back-to-back: a byte may be accepted on the same edge that ends the DONE cycle. Minimum spacing between transfer edges is S+P+H+E+1 cycles.
- With defaults:
  - Short byte: ENABLE high for 240 ns; ready again after 2015 cycles; transfer period 2016.
  - Clear/home: transfer period 82016.

## Test plan
- Reset then release -> all LCD outputs 0, CMD_READY=1, CMD_DONE=0. With CMD_VALID held low for 100 cycles, nothing changes.
- Write RS=0, DATA=0x38 -> DB=0x38 and RS=0 from T; ENABLE high from T+2 through T+13 (12 cycles); CMD_READY low until T+2015; DONE pulse width 1.
- Write RS=0, DATA=0x01 -> identical strobe; CMD_READY returns at T+82015. Repeat with RS=1, DATA=0x01 -> short wait (T+2015).
- CMD_VALID held high over a three-byte stream 0x80, 'D'(0x44), 'M'(0x4D) -> exactly three ENABLE pulses with the correct DB/RS during each. Transfer edges are 2016 cycles apart, and CMD_DATA changes while busy are ignored.
- Assert RESET_N=0 mid-PULSE (ENABLE=1) -> ENABLE=0 asynchronously, DB=0, no CMD_DONE; after release a new byte completes normally.
- Reduced parameters (all =1), random valid/data stream against a reference model -> every accepted byte produces one pulse, DONE count equals the accept count, and LCD_READ_WRITE is never 1.
